// File: rtl/fir_seq_pkg.sv
// Shared types and timing constants for the decimating FIR MAC sequencer.
package fir_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        FLUSH,
        READ,
        DONE
    } seq_state_e;

    localparam int unsigned PIPE_LAT  = 1;
    localparam int unsigned FLUSH_CYC = 1;

    // Cycles from the CLEAR cycle to the out_strobe cycle.
    function automatic int unsigned total_latency(input int unsigned taps);
        return taps + PIPE_LAT + FLUSH_CYC + 2;
    endfunction

endpackage

// File: rtl/fir_tap_addr_gen.sv
// Walks k = 0..TAPS-1 with the matching circular sample address newest-k.
module fir_tap_addr_gen #(
    parameter int unsigned TAPS   = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] newest_i,
    output logic [ADDR_W-1:0] tap_o,
    output logic [ADDR_W-1:0] samp_addr_o,
    output logic              valid_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] tap_q, tap_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;

    always_comb begin
        tap_d   = tap_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (start_i) begin
            tap_d   = '0;
            addr_d  = newest_i;
            valid_d = 1'b1;
            last_d  = 1'b0;
        end else if (valid_q) begin
            if (last_q) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                tap_d  = tap_q + ADDR_W'(1);
                // TAPS is a power of two, so the natural wrap is modulo TAPS
                addr_d = addr_q - ADDR_W'(1);
                last_d = (tap_q == ADDR_W'(TAPS - 2));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tap_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            tap_q   <= tap_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign tap_o       = tap_q;
    assign samp_addr_o = addr_q;
    assign valid_o     = valid_q;
    assign last_o      = last_q;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Write-pointer, decimation counter and convolution FSM driving the shared MAC
// and the sample/coefficient RAM addresses for one FIR channel.
module fir_mac_sequencer
    import fir_seq_pkg::*;
#(
    parameter int unsigned TAPS   = 256,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DECIM  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_strobe,
    output logic              samp_wr_en,
    output logic [ADDR_W-1:0] samp_wr_addr,
    output logic [ADDR_W-1:0] samp_rd_addr,
    output logic [ADDR_W-1:0] coef_rd_addr,
    output logic              mac_reset,
    output logic              mac_wren,
    output logic              mac_zero,
    output logic              mac_rden,
    output logic              out_strobe,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned DEC_W = $clog2(DECIM + 1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEC_W-1:0]  dec_cnt_q, dec_cnt_d;
    logic [ADDR_W-1:0] newest_q, newest_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wr_en_q, wr_en_d;
    logic              last_dly_q;
    logic              mac_reset_q, mac_reset_d;
    logic              mac_wren_q, mac_wren_d;
    logic              mac_zero_q, mac_zero_d;
    logic              mac_rden_q, mac_rden_d;
    logic              out_strobe_q, out_strobe_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;

    logic              trigger;
    logic              gen_start;
    logic              gen_valid;
    logic              gen_last;

    // Circular sample write path and decimation counter, independent of the FSM.
    always_comb begin
        trigger   = in_strobe && (dec_cnt_q == DEC_W'(DECIM - 1));
        wr_ptr_d  = wr_ptr_q;
        dec_cnt_d = dec_cnt_q;
        wr_addr_d = wr_addr_q;
        wr_en_d   = in_strobe;
        if (in_strobe) begin
            wr_addr_d = wr_ptr_q;
            wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
            dec_cnt_d = trigger ? '0 : dec_cnt_q + DEC_W'(1);
        end
    end

    // Convolution FSM; outputs are decoded from the next state and then registered.
    always_comb begin
        state_d   = state_q;
        newest_d  = newest_q;
        gen_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d  = CLEAR;
                    newest_d = wr_ptr_q;
                end
            end
            CLEAR: begin
                state_d   = RUN;
                gen_start = 1'b1;
            end
            RUN: begin
                if (last_dly_q) state_d = FLUSH;
            end
            FLUSH:   state_d = READ;
            READ:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        mac_reset_d  = (state_d == CLEAR);
        mac_wren_d   = gen_valid || (state_d == FLUSH);
        mac_zero_d   = (state_d == FLUSH);
        mac_rden_d   = (state_d == READ);
        out_strobe_d = (state_d == DONE);
        busy_d       = (state_d == CLEAR) || (state_d == RUN) ||
                       (state_d == FLUSH) || (state_d == READ);
        overrun_d    = trigger && (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            dec_cnt_q    <= '0;
            newest_q     <= '0;
            wr_addr_q    <= '0;
            wr_en_q      <= 1'b0;
            last_dly_q   <= 1'b0;
            mac_reset_q  <= 1'b1;
            mac_wren_q   <= 1'b0;
            mac_zero_q   <= 1'b0;
            mac_rden_q   <= 1'b0;
            out_strobe_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            dec_cnt_q    <= dec_cnt_d;
            newest_q     <= newest_d;
            wr_addr_q    <= wr_addr_d;
            wr_en_q      <= wr_en_d;
            last_dly_q   <= gen_last;
            mac_reset_q  <= mac_reset_d;
            mac_wren_q   <= mac_wren_d;
            mac_zero_q   <= mac_zero_d;
            mac_rden_q   <= mac_rden_d;
            out_strobe_q <= out_strobe_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    fir_tap_addr_gen #(
        .TAPS   (TAPS),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .start_i     (gen_start),
        .newest_i    (newest_q),
        .tap_o       (coef_rd_addr),
        .samp_addr_o (samp_rd_addr),
        .valid_o     (gen_valid),
        .last_o      (gen_last)
    );

    assign samp_wr_en   = wr_en_q;
    assign samp_wr_addr = wr_addr_q;
    assign mac_reset    = mac_reset_q;
    assign mac_wren     = mac_wren_q;
    assign mac_zero     = mac_zero_q;
    assign mac_rden     = mac_rden_q;
    assign out_strobe   = out_strobe_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Sequencer bench: RAM/ROM/MAC datapath harness plus a timeline-based reference
// model of the expected control outputs and convolution results.
module tb_fir_mac_sequencer;
    import fir_seq_pkg::*;

    localparam int unsigned TAPS   = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DECIM  = 2;
    localparam int          LAT    = int'(total_latency(TAPS));

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_strobe = 1'b0;
    logic [23:0]       sample_in = '0;
    logic              samp_wr_en;
    logic [ADDR_W-1:0] samp_wr_addr;
    logic [ADDR_W-1:0] samp_rd_addr;
    logic [ADDR_W-1:0] coef_rd_addr;
    logic              mac_reset;
    logic              mac_wren;
    logic              mac_zero;
    logic              mac_rden;
    logic              out_strobe;
    logic              busy;
    logic              overrun;

    fir_mac_sequencer #(
        .TAPS   (TAPS),
        .ADDR_W (ADDR_W),
        .DECIM  (DECIM)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_strobe    (in_strobe),
        .samp_wr_en   (samp_wr_en),
        .samp_wr_addr (samp_wr_addr),
        .samp_rd_addr (samp_rd_addr),
        .coef_rd_addr (coef_rd_addr),
        .mac_reset    (mac_reset),
        .mac_wren     (mac_wren),
        .mac_zero     (mac_zero),
        .mac_rden     (mac_rden),
        .out_strobe   (out_strobe),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Datapath harness: sample RAM, coefficient ROM (coef[k] = k+1), MAC.
    logic [23:0] din_q;
    logic [23:0] ram [TAPS] = '{default: '0};
    logic [23:0] rd_q, cf_q;
    logic [63:0] prod_q, acc_q, accum_out;

    always @(posedge clk) begin
        if (in_strobe) din_q <= sample_in;
        if (samp_wr_en) ram[samp_wr_addr] <= din_q;
        rd_q <= ram[samp_rd_addr];
        cf_q <= 24'(coef_rd_addr) + 24'd1;
        if (mac_reset) begin
            acc_q  <= '0;
            prod_q <= '0;
        end else if (mac_wren) begin
            acc_q  <= acc_q + prod_q;
            prod_q <= mac_zero ? 64'd0 : 64'(rd_q) * 64'(cf_q);
        end
        if (mac_rden) accum_out <= acc_q;
    end

    // Reference model state
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          t0 = 0;
    bit          active = 1'b0;
    int          newest = 0;
    int          wptr = 0;
    int          dcnt = 0;
    bit          dirty = 1'b0;
    longint      exp_y = 0;
    logic [23:0] ring [TAPS] = '{default: '0};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic longint conv(input int nw);
        longint s = 0;
        for (int k = 0; k < int'(TAPS); k++)
            s += longint'(k + 1) * longint'(ring[(nw - k + int'(TAPS)) % int'(TAPS)]);
        return s;
    endfunction

    // Drive one cycle of inputs, then compare every output against the model.
    task automatic step(input bit rst, input bit strb, input int data);
        bit prev_busy;
        bit e_wr_en;
        bit e_ovr;
        int e_wr_addr;
        int d;
        reset     = rst;
        in_strobe = strb;
        sample_in = 24'(data);
        @(posedge clk);
        #1;
        cyc++;
        prev_busy = active && ((cyc - 1 - t0) <= LAT);
        e_wr_en   = 1'b0;
        e_ovr     = 1'b0;
        e_wr_addr = 0;
        if (rst) begin
            active = 1'b0;
            wptr   = 0;
            dcnt   = 0;
        end else if (strb) begin
            e_wr_en   = 1'b1;
            e_wr_addr = wptr;
            ring[wptr] = 24'(data);
            if (prev_busy) dirty = 1'b1;
            if (dcnt == int'(DECIM) - 1) begin
                dcnt = 0;
                if (prev_busy) e_ovr = 1'b1;
                else begin
                    active = 1'b1;
                    t0     = cyc;
                    newest = wptr;
                    dirty  = 1'b0;
                    exp_y  = conv(wptr);
                end
            end else begin
                dcnt++;
            end
            wptr = (wptr + 1) % int'(TAPS);
        end
        d = (active && (cyc - t0) <= LAT) ? cyc - t0 : -1;

        check_eq("wr_en", 64'(samp_wr_en), 64'(e_wr_en));
        if (e_wr_en) check_eq("wr_addr", 64'(samp_wr_addr), 64'(e_wr_addr));
        if (rst) begin
            check_eq("rst_wr_addr", 64'(samp_wr_addr), 64'd0);
            check_eq("rst_rd_addr", 64'(samp_rd_addr), 64'd0);
            check_eq("rst_coef", 64'(coef_rd_addr), 64'd0);
        end
        if (d >= 1 && d <= int'(TAPS)) begin
            check_eq("rd_addr", 64'(samp_rd_addr), 64'((newest - (d - 1) + int'(TAPS)) % int'(TAPS)));
            check_eq("coef_addr", 64'(coef_rd_addr), 64'(d - 1));
        end
        check_eq("mac_reset", 64'(mac_reset), 64'(rst || d == 0));
        check_eq("mac_wren", 64'(mac_wren), 64'(d >= 2 && d <= int'(TAPS) + 2));
        check_eq("mac_zero", 64'(mac_zero), 64'(d == int'(TAPS) + 2));
        check_eq("mac_rden", 64'(mac_rden), 64'(d == int'(TAPS) + 3));
        check_eq("out_strobe", 64'(out_strobe), 64'(d == LAT));
        check_eq("busy", 64'(busy), 64'(d >= 0 && d < LAT));
        check_eq("overrun", 64'(overrun), 64'(e_ovr));
        check_eq("mac_mutex", 64'((32'(mac_reset) + 32'(mac_wren) + 32'(mac_rden)) <= 1), 64'd1);
        if (d == LAT && !dirty) check_eq("accum", accum_out, 64'(exp_y));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0);
    endtask

    initial begin
        // Reset values
        repeat (3) step(1'b1, 1'b0, 0);

        // Impulse then zeros, widely spaced: exercises address order and wrap
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, (i == 0) ? 1 : 0);
            idle(16);
        end

        // Trigger arriving while busy is dropped with a single overrun pulse
        step(1'b0, 1'b1, 5);
        idle(2);
        step(1'b0, 1'b1, 7);
        idle(2);
        step(1'b0, 1'b1, 9);
        idle(1);
        step(1'b0, 1'b1, 11);
        idle(16);
        step(1'b0, 1'b1, 3);
        idle(2);
        step(1'b0, 1'b1, 4);
        idle(16);

        // Reset during RUN at T5, then a clean restart
        for (int tries = 0; tries < 2 && !(active && t0 == cyc); tries++) begin
            if (tries > 0) idle(16);
            step(1'b0, 1'b1, 6);
        end
        check_eq("mid_run_trigger", 64'(active && t0 == cyc), 64'd1);
        idle(5);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 0);
        idle(2);
        step(1'b0, 1'b1, 2);
        idle(3);
        step(1'b0, 1'b1, 8);
        idle(16);

        // Dense random strobes
        for (int i = 0; i < 300; i++)
            step(1'b0, ($urandom % 4) == 0, int'($urandom_range(0, 65535)));
        idle(16);

        // Sparse random strobes with bit-exact results
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, int'($urandom_range(0, 65535)));
            idle(int'($urandom_range(14, 25)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
